spi_regfile: RTL

SPI_REGFILE -- requirements
Module: spi_regfile

---
 rtl/spi_regfile_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_regfile.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared types and frame-geometry helper for the SPI register file.
package spi_regfile_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  // One R/W bit, then the address, then the data.
  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI line, with edge strobes
// derived from the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral exposing a small register file: write frames update
// a register, read frames shift the addressed register back out on cipo.
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       addr_err
);

  localparam int              FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int              CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [ADDR_W:0] NREG_V  = (ADDR_W+1)'(NUM_REGS);

  logic       sclk_rise, sclk_fall;
  logic       ncs_q, ncs_rise, ncs_fall;
  logic       copi_q;
  logic [2:0] unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .q(unused_sync[0]), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs),
    .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi),
    .q(copi_q), .rise(unused_sync[1]), .fall(unused_sync[2])
  );

  state_t                           state, state_nx;
  logic [CNT_W-1:0]                 bit_cnt;
  logic [FRAME_W-1:0]               shift_in, shift_nx;
  logic [DATA_W-1:0]                shift_out, rd_val;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_r;
  logic [ADDR_W-1:0]                addr_q;
  logic                             rw_q, load_pend, commit_pend, armed;
  logic [SYNC_STAGES:0]             vld_pipe;
  logic                             bit_ev, out_ev, addr_ok, last_addr, last_bit;

  // An ncs rising edge wins over any sclk edge seen in the same clk.
  assign bit_ev    = sclk_rise & ~ncs_rise;
  assign out_ev    = sclk_fall & ~ncs_rise;
  assign shift_nx  = {shift_in[FRAME_W-2:0], copi_q};
  assign last_addr = (bit_cnt == CNT_W'(ADDR_W));
  assign last_bit  = (bit_cnt == CNT_W'(FRAME_W - 1));
  assign addr_ok   = ({1'b0, addr_q} < NREG_V);
  assign regs      = regs_r;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (addr_q == ADDR_W'(i)) rd_val = regs_r[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ncs_fall && armed)      state_nx = ADDR;
      ADDR:    if (bit_ev && last_addr)    state_nx = DATA;
      DATA:    if (bit_ev && last_bit)     state_nx = DONE;
      default: ;
    endcase
    if (ncs_rise) state_nx = IDLE;
  end

  // After reset the ncs chain flushes from its idle-high value; a falling
  // edge only counts once a genuine high level has been observed, so a frame
  // already in progress at reset release is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe    <= '0;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      shift_in    <= '0;
      shift_out   <= '0;
      regs_r      <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      load_pend   <= 1'b0;
      commit_pend <= 1'b0;
      wr_pulse    <= 1'b0;
      wr_addr     <= '0;
      addr_err    <= 1'b0;
      cipo        <= 1'b0;
      cipo_oe     <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      addr_err <= 1'b0;
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      if (vld_pipe[SYNC_STAGES] && ncs_q) armed <= 1'b1;

      if (state == IDLE && state_nx == ADDR) begin
        bit_cnt   <= '0;
        shift_in  <= '0;
        shift_out <= '0;
      end

      if ((state == ADDR || state == DATA) && bit_ev) begin
        shift_in <= shift_nx;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end

      if (state == ADDR && state_nx == DATA) begin
        addr_q    <= shift_nx[ADDR_W-1:0];
        rw_q      <= shift_nx[ADDR_W];
        load_pend <= ~shift_nx[ADDR_W];
      end

      if (load_pend) begin
        load_pend <= 1'b0;
        if (state == DATA) begin
          shift_out <= addr_ok ? rd_val : '0;
          cipo_oe   <= 1'b1;
        end
      end

      if (state == DATA && out_ev && cipo_oe) begin
        cipo      <= shift_out[DATA_W-1];
        shift_out <= shift_out << 1;
      end

      if (state == DATA && state_nx == DONE) begin
        if (rw_q)          commit_pend <= 1'b1;
        else if (!addr_ok) addr_err    <= 1'b1;
      end

      if (commit_pend) begin
        commit_pend <= 1'b0;
        if (addr_ok) begin
          for (int i = 0; i < NUM_REGS; i++)
            if (addr_q == ADDR_W'(i)) regs_r[i] <= shift_in[DATA_W-1:0];
          wr_pulse <= 1'b1;
          wr_addr  <= addr_q;
        end else begin
          addr_err <= 1'b1;
        end
      end

      if (state_nx == IDLE) begin
        cipo      <= 1'b0;
        cipo_oe   <= 1'b0;
        load_pend <= 1'b0;
      end
    end
  end

endmodule
